// File: rtl/window3x3_ctrl.sv
// Raster-scan 3x3 window controller: two line buffers, a registered 3x3 window,
// and a frame FSM that meters a downstream FILT_LAT-deep filter.
module window3x3_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FILT_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] win1,
  output logic [DATA_WIDTH-1:0] win2,
  output logic [DATA_WIDTH-1:0] win3,
  output logic [DATA_WIDTH-1:0] win4,
  output logic [DATA_WIDTH-1:0] win5,
  output logic [DATA_WIDTH-1:0] win6,
  output logic [DATA_WIDTH-1:0] win7,
  output logic [DATA_WIDTH-1:0] win8,
  output logic [DATA_WIDTH-1:0] win9,
  output logic                  win_valid,
  output logic                  filt_enable,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [23:0]           out_count
);

  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int DCW = $clog2(FILT_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DCW-1:0]        r_drain_cnt;
  logic                  r_accept_d;
  logic [DATA_WIDTH-1:0] r_win [9];
  logic                  r_win_valid;
  logic [FILT_LAT-1:0]   r_vsr;
  logic                  r_out_valid;
  logic [23:0]           r_out_count;
  logic [DATA_WIDTH-1:0] r_line1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_line2 [IMG_WIDTH];

  logic                  w_start, w_accept, w_last, w_drain;
  logic [FILT_LAT-1:0]   w_vsr_next;

  assign w_start  = (r_state == S_IDLE) && start;
  assign w_accept = pix_valid && pix_ready;
  assign w_last   = (r_col == CW'(IMG_WIDTH - 1)) && (r_row == RW'(IMG_HEIGHT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    pix_ready  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    w_drain    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        pix_ready = 1'b1;
        if (pix_valid && w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_drain = 1'b1;
        if (r_drain_cnt == DCW'(FILT_LAT - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign filt_enable = r_accept_d || w_drain;
  assign w_vsr_next  = (r_vsr << 1) | FILT_LAT'(r_win_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_drain_cnt <= '0;
      r_accept_d  <= 1'b0;
    end else begin
      r_accept_d  <= w_accept;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
      if (w_start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (r_col == CW'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_HEIGHT - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // NOTE: line buffers carry no reset; win_valid gating keeps stale contents out of any valid window.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line2[r_col] <= r_line1[r_col];
      r_line1[r_col] <= pix_in;
    end
  end

  // Window shifts left; new right column is {line2[c], line1[c], pix_in} read before the update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      r_win_valid <= 1'b0;
    end else if (w_start) begin
      r_win_valid <= 1'b0;
    end else if (w_accept) begin
      r_win[0]    <= r_win[1];
      r_win[1]    <= r_win[2];
      r_win[2]    <= r_line2[r_col];
      r_win[3]    <= r_win[4];
      r_win[4]    <= r_win[5];
      r_win[5]    <= r_line1[r_col];
      r_win[6]    <= r_win[7];
      r_win[7]    <= r_win[8];
      r_win[8]    <= pix_in;
      r_win_valid <= (r_row >= RW'(2)) && (r_col >= CW'(2));
    end
  end

  // Valid pipeline mirrors the filter; cleared at frame start so no bit leaks across frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsr       <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
    end else if (w_start) begin
      r_vsr       <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
    end else begin
      r_out_valid <= filt_enable && w_vsr_next[FILT_LAT-1];
      if (filt_enable) r_vsr <= w_vsr_next;
      if (filt_enable && w_vsr_next[FILT_LAT-1] && (r_out_count != '1))
        r_out_count <= r_out_count + 1'b1;
    end
  end

  assign win1      = r_win[0];
  assign win2      = r_win[1];
  assign win3      = r_win[2];
  assign win4      = r_win[3];
  assign win5      = r_win[4];
  assign win6      = r_win[5];
  assign win7      = r_win[6];
  assign win8      = r_win[7];
  assign win9      = r_win[8];
  assign win_valid = r_win_valid;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;

endmodule
